if_fetch_unit: RTL and testbench

Instruction-fetch stage that consumes the program counter produced by the PC register and issues instruction-memory reads. It buffers in-order responses in a small FIFO and presents them to decode. It back-pressures PC generation through a hold flag and discards stale responses after a jump or branch redirect. It sits between the PC register, the instruction memory port and the IF/ID boundary.

---
 rtl/if_fetch_unit_pkg.sv | 28 ++
 rtl/if_fetch_unit_fetch_fifo.sv | 53 +++++
 rtl/if_fetch_unit.sv | 117 +++++++++++
 tb/tb_if_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// The entry gains a misalign flag only when FETCH_MISALIGN_CHECK_EN is defined.
package if_fetch_unit_pkg;

  typedef logic [31:0] InstAddrBus;
  typedef logic [31:0] InstBus;

  localparam logic       RstEnable    = 1'b0;
  localparam InstBus     INST_NOP     = 32'h0000_0013;
  localparam InstAddrBus CpuResetAddr = 32'h0000_0000;

  typedef struct packed {
    InstAddrBus addr;
    InstBus     inst;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic       misalign;
`endif
  } fetch_entry_t;

  function automatic fetch_entry_t reset_entry();
    fetch_entry_t e;
    e      = '0;
    e.addr = CpuResetAddr;
    e.inst = INST_NOP;
    return e;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of fetch entries with clear; head is read straight from storage.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned  DEPTH     = 4,
  parameter fetch_entry_t RST_ENTRY = reset_entry()
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic           do_push, do_pop;

  // A push at full is legal when the same cycle pops the head slot.
  always_comb begin
    do_pop  = pop & (count != '0);
    do_push = push & ((count != CW'(DEPTH)) | do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RST_ENTRY;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: credit-limited memory requests, in-order response FIFO, flush discard.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned PCs into NOP entries flagged inst_misalign_o.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  InstAddrBus pc_i,
  input  logic       flush_i,
  output logic       hold_o,
  output logic       req_valid_o,
  output InstAddrBus req_addr_o,
  input  logic       req_ready_i,
  input  logic       rsp_valid_i,
  input  InstBus     rsp_data_i,
  output logic       inst_valid_o,
  output InstBus     inst_o,
  output InstAddrBus inst_addr_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic       inst_misalign_o,
`endif
  input  logic       inst_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [CW-1:0] live_cnt, disc_cnt, fifo_cnt, aq_cnt;
  logic [CW+1:0] credit_sum;
  logic          can_req, pc_misaligned, accept, mis_push;
  logic          rsp_live, rsp_disc, if_push;
  fetch_entry_t  aq_push_data, aq_head, if_push_data, if_head;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign pc_misaligned   = |pc_i[1:0];
  assign req_addr_o      = pc_i;
  assign inst_misalign_o = if_head.misalign;
  logic unused_ok;
  assign unused_ok = ^{aq_head.inst, aq_head.misalign, aq_cnt};
`else
  assign pc_misaligned = 1'b0;
  assign req_addr_o    = {pc_i[31:2], 2'b00};
  logic unused_ok;
  assign unused_ok = ^{pc_i[1:0], aq_head.inst, aq_cnt};
`endif

  always_comb begin
    credit_sum  = (CW+2)'(live_cnt) + (CW+2)'(disc_cnt) + (CW+2)'(fifo_cnt);
    can_req     = credit_sum < (CW+2)'(DEPTH);
    req_valid_o = rst_n & can_req & ~flush_i & ~pc_misaligned;
    accept      = req_valid_o & req_ready_i;
    // Misaligned entries queue behind every kept response still in flight.
    mis_push    = rst_n & can_req & ~flush_i & pc_misaligned & (live_cnt == '0);
    hold_o      = ~rst_n | (~flush_i & ~(accept | mis_push));
    rsp_disc    = rsp_valid_i & (disc_cnt != '0);
    rsp_live    = rsp_valid_i & (disc_cnt == '0);
    if_push     = (rsp_live & ~flush_i) | mis_push;
  end

  always_comb begin
    aq_push_data      = '0;
    aq_push_data.addr = req_addr_o;
    if_push_data      = '0;
    if (mis_push) begin
      if_push_data.addr = pc_i;
      if_push_data.inst = INST_NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
      if_push_data.misalign = 1'b1;
`endif
    end else begin
      if_push_data.addr = aq_head.addr;
      if_push_data.inst = rsp_data_i;
    end
  end

  // On flush every kept request in flight becomes stale; a response landing now is one of them.
  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      live_cnt <= '0;
      disc_cnt <= '0;
    end else if (flush_i) begin
      live_cnt <= '0;
      disc_cnt <= disc_cnt + live_cnt - CW'(rsp_valid_i);
    end else begin
      live_cnt <= live_cnt + CW'(accept) - CW'(rsp_live);
      disc_cnt <= disc_cnt - CW'(rsp_disc);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_addr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_i),
    .push      (accept),
    .push_data (aq_push_data),
    .pop       (rsp_live),
    .head      (aq_head),
    .count     (aq_cnt)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_inst_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_i),
    .push      (if_push),
    .push_data (if_push_data),
    .pop       (inst_valid_o & inst_ready_i),
    .head      (if_head),
    .count     (fifo_cnt)
  );

  assign inst_valid_o = (fifo_cnt != '0);
  assign inst_o       = if_head.inst;
  assign inst_addr_o  = if_head.addr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic vs a queue model.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n, flush_i, hold_o, req_valid_o, req_ready_i, rsp_valid_i;
  logic       inst_valid_o, inst_ready_i;
  InstAddrBus pc_i, req_addr_o, inst_addr_o;
  InstBus     rsp_data_i, inst_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic       inst_misalign_o;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .hold_o       (hold_o),
    .req_valid_o  (req_valid_o),
    .req_addr_o   (req_addr_o),
    .req_ready_i  (req_ready_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_data_i   (rsp_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
`ifdef FETCH_MISALIGN_CHECK_EN
    .inst_misalign_o (inst_misalign_o),
`endif
    .inst_ready_i (inst_ready_i)
  );

  typedef struct { InstAddrBus addr; InstBus data; logic mis; } ent_t;
  typedef struct { InstAddrBus addr; logic stale; } out_t;
  typedef struct { InstBus data; int unsigned due; } mrsp_t;

  ent_t        fifo_q[$];
  out_t        out_q[$];
  mrsp_t       mem_q[$];
  InstAddrBus  pc, flush_target;
  int unsigned cyc, lat, rst_cycles;
  int          checks, errors;

  function automatic InstBus mem_word(InstAddrBus a);
    return {a[15:0] ^ 16'hBEEF, a[17:2]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, check outputs against the model, then advance the model.
  task automatic cycle();
    int unsigned live;
    logic can, mis, e_req, e_mpush, e_acc, e_hold, pop;
    ent_t e;
    out_t o;
    mrsp_t m;
    pc_i        = pc;
    rsp_valid_i = rst_n && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rsp_data_i  = rsp_valid_i ? mem_q[0].data : $urandom;
    #1;
    live = 0;
    foreach (out_q[i]) if (!out_q[i].stale) live++;
    can = (out_q.size() + fifo_q.size()) < DEPTH;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis = (pc[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    e_req   = rst_n && can && !flush_i && !mis;
    e_mpush = rst_n && can && !flush_i && mis && (live == 0);
    e_acc   = e_req && req_ready_i;
    e_hold  = !rst_n || (!flush_i && !e_acc && !e_mpush);
    chk("req_valid", req_valid_o, e_req);
    chk("hold", hold_o, e_hold);
    if (e_req) chk("req_addr", req_addr_o, pc & ~32'h3);
    if (rst_n || rst_cycles >= 1) begin
      chk("inst_valid", inst_valid_o, fifo_q.size() != 0);
      if (fifo_q.size() != 0) begin
        chk("inst", inst_o, fifo_q[0].data);
        chk("inst_addr", inst_addr_o, fifo_q[0].addr);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("misalign", inst_misalign_o, fifo_q[0].mis);
`endif
      end
    end
    if (!rst_n && rst_cycles >= 1) begin
      chk("rst_inst", inst_o, INST_NOP);
      chk("rst_inst_addr", inst_addr_o, CpuResetAddr);
    end
    @(posedge clk);
    if (!rst_n) begin
      fifo_q.delete(); out_q.delete(); mem_q.delete();
      pc = CpuResetAddr;
      rst_cycles++;
    end else begin
      rst_cycles = 0;
      pop = (fifo_q.size() != 0) && inst_ready_i && !flush_i;
      if (pop) void'(fifo_q.pop_front());
      if (rsp_valid_i) begin
        o = out_q.pop_front();
        m = mem_q.pop_front();
        if (!o.stale && !flush_i) begin
          e.addr = o.addr; e.data = mem_word(o.addr); e.mis = 1'b0;
          fifo_q.push_back(e);
        end
      end
      if (e_mpush) begin
        e.addr = pc; e.data = INST_NOP; e.mis = 1'b1;
        fifo_q.push_back(e);
      end
      if (flush_i) begin
        fifo_q.delete();
        foreach (out_q[i]) out_q[i].stale = 1'b1;
      end
      if (e_acc) begin
        o.addr = pc & ~32'h3; o.stale = 1'b0;
        out_q.push_back(o);
        m.data = mem_word(o.addr); m.due = cyc + lat;
        mem_q.push_back(m);
      end
      if (flush_i)      pc = flush_target;
      else if (!e_hold) pc = pc + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(int unsigned new_lat);
    rst_n = 1'b0; flush_i = 1'b0;
    lat = new_lat;
    repeat (3) cycle();
    rst_n = 1'b1;
  endtask

  task automatic run(int unsigned n, logic rdy, logic irdy);
    req_ready_i = rdy; inst_ready_i = irdy; flush_i = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic flush_to(InstAddrBus target);
    flush_i = 1'b1; flush_target = target;
    cycle();
    flush_i = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; rst_cycles = 0;
    pc = CpuResetAddr; flush_target = '0;
    rst_n = 1'b0; flush_i = 1'b0; req_ready_i = 1'b1; inst_ready_i = 1'b1;
    rsp_valid_i = 1'b0; rsp_data_i = '0; pc_i = pc;

    // Single-cycle memory, streaming fetch from reset.
    do_reset(1);
    run(12, 1'b1, 1'b1);

    // Decode stalled: credit exhausts at DEPTH, then drains.
    do_reset(1);
    run(8, 1'b1, 1'b0);
    chk("pc_stalled", pc, CpuResetAddr + 32'd16);
    run(8, 1'b1, 1'b1);

    // Three-cycle memory: two requests in flight, then redirect.
    do_reset(3);
    run(2, 1'b1, 1'b1);
    flush_to(32'h100);
    run(10, 1'b1, 1'b1);

    // Flush coinciding with a response and a pop.
    do_reset(1);
    run(4, 1'b1, 1'b1);
    flush_to(32'h40);
    run(6, 1'b1, 1'b1);

    // Memory not ready for five cycles.
    do_reset(1);
    run(3, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    run(5, 1'b1, 1'b1);

`ifdef FETCH_MISALIGN_CHECK_EN
    do_reset(2);
    run(3, 1'b1, 1'b1);
    flush_to(32'h102);
    run(6, 1'b1, 1'b1);
    flush_to(32'h200);
    run(6, 1'b1, 1'b1);
`endif

    // Randomized traffic with occasional redirects and resets.
    do_reset($urandom_range(1, 4));
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 4));
      req_ready_i  = ($urandom_range(0, 3) != 0);
      inst_ready_i = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 19) == 0);
      flush_target = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      cycle();
    end
    flush_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
